mac_inner_product: RTL

- Sequential, parametrised successor to the combinational inner-product block.
- Accepts two N-element vectors in one valid/ready transfer and computes their unsigned inner product.
- Uses LANES multipliers per cycle over N/LANES beats, then presents the result on a valid/ready output.
- Selectable wrap or saturate output narrowing, plus an overflow flag; intended as the dot-product engine inside the matrix-vector datapath.

---
 rtl/mac_inner_product.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mac_inner_product.sv
`default_nettype none
// ============================================================================
// Module   : mac_inner_product
// Purpose  : Sequential unsigned inner product of two N-element vectors using
//            LANES multipliers per beat. The full-width sum is narrowed to OW
//            bits (wrap or saturate) with an overflow flag. Input and output
//            use valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module mac_inner_product #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int LANES = 1,
  parameter int OW    = 8,
  parameter int SAT   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] inp1,
  input  logic [N*DW-1:0] inp2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   outp,
  output logic            out_ovf
);

  // The accumulator is wide enough for N full-scale products and never wraps.
  localparam int AW    = 2*DW + $clog2(N);
  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N*DW-1:0] a_q, a_d;
  logic [N*DW-1:0] b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [OW-1:0]   outp_q, outp_d;
  logic            ovf_q, ovf_d;

  logic [2*DW-1:0] prod [LANES];
  logic [AW-1:0]   lane_sum;
  logic [AW-1:0]   full_sum;
  logic            full_ovf;
  logic [OW-1:0]   narrowed;
  logic [N*DW-1:0] a_shift;
  logic [N*DW-1:0] b_shift;

  // The operand copies are consumed from the bottom: after each beat they are
  // shifted down by one beat, so the lanes always read the low LANES elements.
  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      assign prod[l] = {{DW{1'b0}}, a_q[l*DW +: DW]} * {{DW{1'b0}}, b_q[l*DW +: DW]};
    end

    if (LANES < N) begin : g_shift
      assign a_shift = {{(LANES*DW){1'b0}}, a_q[N*DW-1:LANES*DW]};
      assign b_shift = {{(LANES*DW){1'b0}}, b_q[N*DW-1:LANES*DW]};
    end else begin : g_shift_none
      assign a_shift = '0;
      assign b_shift = '0;
    end

    if (OW < AW) begin : g_ovf
      assign full_ovf = |full_sum[AW-1:OW];
    end else begin : g_ovf_none
      assign full_ovf = 1'b0;
    end
  endgenerate

  // Sum the products of the current beat on top of the running accumulator.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + AW'(prod[i]);
    end
  end

  assign full_sum = acc_q + lane_sum;
  assign narrowed = ((SAT != 0) && full_ovf) ? {OW{1'b1}} : full_sum[OW-1:0];

  // Next-state and datapath updates for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    outp_d  = outp_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = inp1;
          b_d     = inp2;
          acc_d   = '0;
          beat_d  = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d  = full_sum;
        a_d    = a_shift;
        b_d    = b_shift;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          outp_d  = narrowed;
          ovf_d   = full_ovf;
          beat_d  = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      outp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      outp_q  <= outp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign outp      = outp_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire
